// File: rtl/led_pkg.sv
// Shared types and constants for the ping-pong LED controller.
package led_pkg;

  // Sweep states; OFF is entered only through reset.
  typedef enum logic [2:0] {
    OFF = 3'd0,
    S0  = 3'd1,
    S1  = 3'd2,
    S2  = 3'd3,
    S3  = 3'd4,
    S4  = 3'd5,
    S5  = 3'd6
  } state_t;

  localparam logic [3:0] P0 = 4'b0001;
  localparam logic [3:0] P1 = 4'b0010;
  localparam logic [3:0] P2 = 4'b0100;
  localparam logic [3:0] P3 = 4'b1000;

  // Prescaler width: at least one bit even when every cycle is a tick.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Switch synchronizer and step prescaler: one-cycle tick every TICK_DIV enabled cycles.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic res_n,
  input  logic sw,
  output logic tick
);

  localparam int unsigned CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic          sw_meta;
  logic          sw_s;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the raw slide switch.
  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      sw_meta <= 1'b0;
      sw_s    <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
    end
  end

  // Prescaler counts only while enabled and holds (not clears) while paused.
  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      cnt <= '0;
    end else if (sw_s) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Tick on the enabled cycle where the prescaler wraps.
  always_comb begin
    tick = sw_s && (cnt == LAST);
  end

endmodule

// File: rtl/led.sv
// Four-LED ping-pong running light, stepping on a prescaled tick while sw is on.
module led
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       res_n,
  output logic [3:0] data,
  input  logic       sw
);

  state_t state;
  state_t state_nxt;
  logic   tick;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .res_n (res_n),
    .sw    (sw),
    .tick  (tick)
  );

  // State register; reset drops the LEDs immediately.
  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      state <= OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: advance one position per tick, bouncing between the ends.
  always_comb begin
    state_nxt = state;
    if (tick) begin
      unique case (state)
        OFF:     state_nxt = S0;
        S0:      state_nxt = S1;
        S1:      state_nxt = S2;
        S2:      state_nxt = S3;
        S3:      state_nxt = S4;
        S4:      state_nxt = S5;
        S5:      state_nxt = S0;
        default: state_nxt = OFF;
      endcase
    end
  end

  // LED decode straight from the state register so data is glitch-free.
  always_comb begin
    data = '0;
    unique case (state)
      S0:      data = P0;
      S1:      data = P1;
      S2:      data = P2;
      S3:      data = P3;
      S4:      data = P2;
      S5:      data = P1;
      default: data = '0;
    endcase
  end

endmodule

// File: tb/tb_led.sv
// Scoreboard bench for led: TICK_DIV=4 and TICK_DIV=1 instances.
module tb_led;

  logic       clk = 1'b0;
  logic       res4 = 1'b1;
  logic       sw4 = 1'b0;
  logic [3:0] data4;
  logic       res1 = 1'b1;
  logic       sw1 = 1'b0;
  logic [3:0] data1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  led #(.TICK_DIV(4)) dut4 (
    .clk   (clk),
    .res_n (res4),
    .data  (data4),
    .sw    (sw4)
  );

  led #(.TICK_DIV(1)) dut1 (
    .clk   (clk),
    .res_n (res1),
    .data  (data1),
    .sw    (sw1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [3:0] got);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      check(tag, {28'd0, got}, {28'd0, exp_q.pop_front()});
    end
  endtask

  // Advance one edge, sample 1 ns later, compare against the scoreboard.
  task automatic edge_chk(input string tag, input bit sel);
    @(posedge clk);
    #1;
    pop_cmp(tag, sel ? data1 : data4);
    check({tag, "_onehot4"}, 32'($onehot0(data4)), 32'd1);
    check({tag, "_onehot1"}, 32'($onehot0(data1)), 32'd1);
  endtask

  task automatic push_n(input logic [3:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  initial begin
    logic [3:0] seq4 [7];
    logic [3:0] seq1 [6];
    seq4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

    // Reset held 100 cycles with the switch toggling.
    for (int unsigned i = 0; i < 100; i++) begin
      sw4 = ~sw4;
      exp_q.push_back(4'b0000);
      edge_chk("rst_hold", 1'b0);
    end
    check("rst_cnt", 32'(dut4.u_tick_gen.cnt), 32'd0);

    // Release with sw on: five quiet edges, then the sweep at 4 edges per step.
    res4 = 1'b0;
    sw4  = 1'b1;
    push_n(4'b0000, 5);
    for (int unsigned s = 0; s < 7; s++) push_n(seq4[s], 4);
    push_n(4'b0010, 4);
    push_n(4'b0100, 2);
    while (exp_q.size() > 0) edge_chk("sweep4", 1'b0);

    // Pause one edge into S2: two more counted edges, then frozen.
    sw4 = 1'b0;
    push_n(4'b0100, 52);
    while (exp_q.size() > 0) edge_chk("pause", 1'b0);
    check("pause_cnt", 32'(dut4.u_tick_gen.cnt), 32'd3);

    // Resume: synchronizer delay, then the pending count completes at once.
    sw4 = 1'b1;
    push_n(4'b0100, 2);
    push_n(4'b1000, 2);
    while (exp_q.size() > 0) edge_chk("resume", 1'b0);

    // Asynchronous reset between edges while lit at 1000.
    #2;
    res4 = 1'b1;
    #1;
    exp_q.push_back(4'b0000);
    pop_cmp("async_rst", data4);
    push_n(4'b0000, 3);
    while (exp_q.size() > 0) edge_chk("rst_after", 1'b0);

    // TICK_DIV=1: two quiet edges, then a step every clock.
    res1 = 1'b0;
    sw1  = 1'b1;
    push_n(4'b0000, 2);
    for (int unsigned p = 0; p < 2; p++)
      for (int unsigned s = 0; s < 6; s++) exp_q.push_back(seq1[s]);
    while (exp_q.size() > 0) edge_chk("sweep1", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
